// File: rtl/audio_framer_if.sv
// audio_framer_if: sample input, Avalon-ST sink and status signals of audio_framer
interface audio_framer_if #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 1024
);
    logic [DATA_W-1:0]           audio_in;
    logic                        audio_valid;
    logic                        sink_ready;
    logic                        sink_valid;
    logic                        sink_sop;
    logic                        sink_eop;
    logic [DATA_W-1:0]           sink_real;
    logic [DATA_W-1:0]           sink_imag;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        overflow;
    modport slave (
        input  audio_in, audio_valid, sink_ready,
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fifo_level, overflow
    );
    modport master (
        output audio_in, audio_valid, sink_ready,
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, fifo_level, overflow
    );
endinterface

// File: rtl/audio_framer.sv
// audio_framer: buffers audio samples and emits whole FRAME_LEN-sample Avalon-ST frames
module audio_framer #(
    parameter int DATA_W     = 16,
    parameter int FRAME_LEN  = 512,
    parameter int FIFO_DEPTH = 1024
) (
    input logic           clk,
    input logic           rst,
    audio_framer_if.slave bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int IW    = $clog2(FRAME_LEN);
    localparam int LVL_W = AW + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [IW:0]       loaded_q, loaded_d;
    logic [IW-1:0]     idx;
    logic              valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] real_q, real_d;
    logic              wr, have, eop_xfer, start, load;

    // sample storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= bus.audio_in;
    end

    // frame sequencing, output register loading and FIFO bookkeeping
    always_comb begin
        wr       = bus.audio_valid && level_q < LVL_W'(FIFO_DEPTH);
        have     = level_q >= LVL_W'(FRAME_LEN);
        eop_xfer = valid_q && bus.sink_ready && eop_q;
        start    = have && (state_q == IDLE || eop_xfer);
        load     = start || (state_q == STREAM && !loaded_q[IW] && (!valid_q || bus.sink_ready));
        idx      = start ? '0 : loaded_q[IW-1:0];
        state_d  = start ? STREAM : eop_xfer ? IDLE : state_q;
        loaded_d = start ? (IW+1)'(1) : load ? loaded_q + 1'b1 : eop_xfer ? '0 : loaded_q;
        valid_d  = load || (valid_q && !bus.sink_ready);
        real_d   = load ? mem_q[rd_ptr_q] : real_q;
        sop_d    = load ? idx == '0 : sop_q && valid_d;
        eop_d    = load ? idx == IW'(FRAME_LEN - 1) : eop_q && valid_d;
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(load);
        level_d  = level_q + LVL_W'(wr) - LVL_W'(load);
        ovf_d    = ovf_q || (bus.audio_valid && level_q == LVL_W'(FIFO_DEPTH));
    end

    // state register with asynchronous reset discarding any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            loaded_q <= '0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            real_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            loaded_q <= loaded_d;
            valid_q  <= valid_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            real_q   <= real_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.sink_valid = valid_q;
    assign bus.sink_sop   = sop_q;
    assign bus.sink_eop   = eop_q;
    assign bus.sink_real  = real_q;
    assign bus.sink_imag  = '0;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;
endmodule
